// File: rtl/tile_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tile_result_drain
// Purpose  : Output-side collector for the PE tile array. Captures a full
//            TILE_SIZE x TILE_SIZE accumulator tile on tile_valid, converts
//            every element to DATA_WIDTH (optional shift + half-up rounding,
//            then saturation), stores it in a two-slot ping-pong buffer and
//            streams it out row by row over a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            tile_valid, tile_data[row][col], requant_en -> tile input
//            tile_ready                                  -> slot free
//            row_valid, row_ready, row_data[col], row_idx, row_last
//            overflow_err, sat_seen                      -> sticky status
// Revision : 1.0 - initial release
// ============================================================================
module tile_result_drain #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 tile_valid,
  input  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0]   tile_data,
  input  logic                                                 requant_en,
  output logic                                                 tile_ready,
  output logic                                                 row_valid,
  input  logic                                                 row_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]                 row_data,
  output logic [$clog2(TILE_SIZE)-1:0]                         row_idx,
  output logic                                                 row_last,
  output logic                                                 overflow_err,
  output logic                                                 sat_seen
);

  localparam int RW = $clog2(TILE_SIZE);
  localparam logic [RW-1:0] LAST_ROW = RW'(TILE_SIZE - 1);

  // Conversion is done one bit wider than the accumulator so the rounding
  // add can never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF  = (ACC_WIDTH + 1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] MAX_W = (ACC_WIDTH + 1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] MIN_W = -MAX_W - (ACC_WIDTH + 1)'(1);
  localparam logic [DATA_WIDTH-1:0]     MAX_OUT = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]     MIN_OUT = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  // Buffer state
  logic [1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] slot;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [RW-1:0] row_cnt;

  // Parallel conversion of the incoming tile
  logic [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] conv_tile;
  logic [TILE_SIZE*TILE_SIZE-1:0]                      sat_vec;

  for (genvar r = 0; r < TILE_SIZE; r++) begin : g_row
    for (genvar c = 0; c < TILE_SIZE; c++) begin : g_col
      logic signed [ACC_WIDTH:0] ext;
      logic signed [ACC_WIDTH:0] rounded;
      logic signed [ACC_WIDTH:0] t;
      logic                      hi;
      logic                      lo;

      assign ext     = {tile_data[r][c][ACC_WIDTH-1], tile_data[r][c]};
      // Adding one half then shifting arithmetically gives round-half-up
      // (towards +inf), so -1.5 becomes -1.
      assign rounded = (ext + HALF) >>> FRAC_BITS;
      assign t       = requant_en ? rounded : ext;
      assign hi      = (t > MAX_W);
      assign lo      = (t < MIN_W);

      assign conv_tile[r][c]          = hi ? MAX_OUT : (lo ? MIN_OUT : t[DATA_WIDTH-1:0]);
      assign sat_vec[r*TILE_SIZE + c] = hi | lo;
    end
  end

  logic accept;
  logic pop;
  logic last_pop;

  assign tile_ready = (count < 2'd2);
  assign accept     = tile_valid && tile_ready;
  assign pop        = row_valid && row_ready;
  assign last_pop   = pop && (row_cnt == LAST_ROW);

  // Output path is a pure register mux; slots reset to zero so row_data
  // reads zero out of reset.
  assign row_valid = (count != 2'd0);
  assign row_data  = slot[rd_ptr][row_cnt];
  assign row_idx   = row_cnt;
  assign row_last  = row_valid && (row_cnt == LAST_ROW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot         <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      row_cnt      <= '0;
      overflow_err <= 1'b0;
      sat_seen     <= 1'b0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= conv_tile;
        wr_ptr       <= ~wr_ptr;
        if (|sat_vec) begin
          sat_seen <= 1'b1;
        end
      end

      if (tile_valid && !tile_ready) begin
        overflow_err <= 1'b1;
      end

      if (pop) begin
        if (row_cnt == LAST_ROW) begin
          row_cnt <= '0;
          rd_ptr  <= ~rd_ptr;
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end

      // Accept and final-row pop in the same cycle leave count unchanged.
      if (accept && !last_pop) begin
        count <= count + 2'd1;
      end else if (!accept && last_pop) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_result_drain
// Purpose  : Self-checking bench for tile_result_drain (TILE_SIZE=4,
//            DATA_WIDTH=16, ACC_WIDTH=32, FRAC_BITS=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_result_drain;

  logic                         clk;
  logic                         rst;
  logic                         tile_valid;
  logic [3:0][3:0][31:0]        tile_data;
  logic                         requant_en;
  logic                         tile_ready;
  logic                         row_valid;
  logic                         row_ready;
  logic [3:0][15:0]             row_data;
  logic [1:0]                   row_idx;
  logic                         row_last;
  logic                         overflow_err;
  logic                         sat_seen;

  int tests;
  int fails;

  tile_result_drain #(
    .TILE_SIZE (4),
    .DATA_WIDTH(16),
    .ACC_WIDTH (32),
    .FRAC_BITS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tile_valid  (tile_valid),
    .tile_data   (tile_data),
    .requant_en  (requant_en),
    .tile_ready  (tile_ready),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_last    (row_last),
    .overflow_err(overflow_err),
    .sat_seen    (sat_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row of four inputs, its requant mode, the hand-computed outputs and
  // the expected sticky sat_seen after the tile.
  typedef struct {
    logic [31:0] x[4];
    logic        rq;
    logic [15:0] e[4];
    logic        sat_after;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synthetic tile for the handshake sequences: element = k*100 + r*10 + c.
  function automatic logic [3:0][3:0][31:0] mk_tile(input int k);
    logic [3:0][3:0][31:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = 32'(k * 100 + r * 10 + c);
    return t;
  endfunction

  function automatic logic [63:0] mk_row(input int k, input int r);
    logic [3:0][15:0] v;
    for (int c = 0; c < 4; c++) v[c] = 16'(k * 100 + r * 10 + c);
    return 64'(v);
  endfunction

  task automatic check_row(input string name, input int k, input int r);
    check({name, " valid"}, 64'(row_valid), 64'd1);
    check({name, " data"},  64'(row_data),  mk_row(k, r));
    check({name, " idx"},   64'(row_idx),   64'(r));
    check({name, " last"},  64'(row_last),  64'(r == 3));
  endtask

  // Presents a tile for exactly one clock edge; leaves us #1 after that edge.
  task automatic send(input logic [3:0][3:0][31:0] t, input logic rq);
    tile_data  = t;
    requant_en = rq;
    tile_valid = 1'b1;
    tick();
    tile_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0][3:0][31:0] t;
    logic [3:0][15:0]      er;

    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    tile_valid = 1'b0;
    tile_data  = '0;
    requant_en = 1'b0;
    row_ready  = 1'b0;

    vecs[0].x = '{32'd384, 32'(-384), 32'd128, 32'd0};
    vecs[0].rq = 1'b1;
    vecs[0].e = '{16'd2, 16'(-1), 16'd1, 16'd0};
    vecs[0].sat_after = 1'b0;

    vecs[1].x = '{32'd127, 32'(-128), 32'(-129), 32'd255};
    vecs[1].rq = 1'b1;
    vecs[1].e = '{16'd0, 16'd0, 16'(-1), 16'd1};
    vecs[1].sat_after = 1'b0;

    vecs[2].x = '{32'd5, 32'(-7), 32'd0, 32'd1000};
    vecs[2].rq = 1'b0;
    vecs[2].e = '{16'd5, 16'(-7), 16'd0, 16'd1000};
    vecs[2].sat_after = 1'b0;

    vecs[3].x = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd8388352, 32'(-8388608)};
    vecs[3].rq = 1'b1;
    vecs[3].e = '{16'd32767, 16'h8000, 16'd32767, 16'h8000};
    vecs[3].sat_after = 1'b1;

    vecs[4].x = '{32'd40000, 32'(-40000), 32'd32767, 32'(-32768)};
    vecs[4].rq = 1'b0;
    vecs[4].e = '{16'd32767, 16'h8000, 16'd32767, 16'h8000};
    vecs[4].sat_after = 1'b1;

    // Reset values while rst is held
    #2;
    check("reset tile_ready",   64'(tile_ready),   64'd1);
    check("reset row_valid",    64'(row_valid),    64'd0);
    check("reset row_data",     64'(row_data),     64'd0);
    check("reset row_idx",      64'(row_idx),      64'd0);
    check("reset row_last",     64'(row_last),     64'd0);
    check("reset overflow_err", 64'(overflow_err), 64'd0);
    check("reset sat_seen",     64'(sat_seen),     64'd0);
    do_reset();

    // Conversion vectors: row r of the tile is the vector rotated by r.
    row_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = vecs[v].x[(c + r) % 4];
      send(t, vecs[v].rq);
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) er[c] = vecs[v].e[(c + r) % 4];
        check($sformatf("vec%0d row%0d valid", v, r), 64'(row_valid), 64'd1);
        check($sformatf("vec%0d row%0d data", v, r),  64'(row_data),  64'(er));
        check($sformatf("vec%0d row%0d idx", v, r),   64'(row_idx),   64'(r));
        check($sformatf("vec%0d row%0d last", v, r),  64'(row_last),  64'(r == 3));
        tick();
      end
      check($sformatf("vec%0d drained", v),  64'(row_valid), 64'd0);
      check($sformatf("vec%0d sat_seen", v), 64'(sat_seen),  64'(vecs[v].sat_after));
    end
    check("vec overflow_err", 64'(overflow_err), 64'd0);

    // Backpressure and overflow
    do_reset();
    row_ready = 1'b0;
    send(mk_tile(1), 1'b0);
    check("bp tile_ready after 1", 64'(tile_ready), 64'd1);
    send(mk_tile(2), 1'b0);
    check("bp tile_ready after 2", 64'(tile_ready), 64'd0);
    check("bp overflow before drop", 64'(overflow_err), 64'd0);
    send(mk_tile(3), 1'b0);
    check("bp overflow after drop", 64'(overflow_err), 64'd1);
    row_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_row($sformatf("bp row%0d", i), 1 + i / 4, i % 4);
      check($sformatf("bp row%0d tile_ready", i), 64'(tile_ready), 64'(i >= 4));
      tick();
    end
    check("bp drained", 64'(row_valid), 64'd0);

    // Accept in the same cycle as the final-row pop
    do_reset();
    row_ready = 1'b1;
    send(mk_tile(4), 1'b0);
    tick();
    tick();
    tick();
    check_row("sim before", 4, 3);
    send(mk_tile(5), 1'b0);
    check_row("sim new row0", 5, 0);
    check("sim tile_ready", 64'(tile_ready), 64'd1);
    for (int r = 1; r < 4; r++) begin
      tick();
      check_row($sformatf("sim row%0d", r), 5, r);
    end
    tick();
    check("sim drained", 64'(row_valid), 64'd0);

    // Stall stability at row 2
    do_reset();
    row_ready = 1'b1;
    send(mk_tile(6), 1'b0);
    tick();
    tick();
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_row($sformatf("stall cyc%0d", i), 6, 2);
      tick();
    end
    check_row("stall resume", 6, 2);
    row_ready = 1'b1;
    tick();
    check_row("stall after", 6, 3);
    tick();
    check("stall drained", 64'(row_valid), 64'd0);

    // Reset mid-operation with two tiles buffered at row 1
    do_reset();
    row_ready = 1'b0;
    send(mk_tile(7), 1'b0);
    send(mk_tile(8), 1'b0);
    row_ready = 1'b1;
    tick();
    row_ready = 1'b0;
    check_row("mid pre-reset", 7, 1);
    check("mid pre tile_ready", 64'(tile_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst row_valid",  64'(row_valid),  64'd0);
    check("mid rst row_data",   64'(row_data),   64'd0);
    check("mid rst row_idx",    64'(row_idx),    64'd0);
    check("mid rst row_last",   64'(row_last),   64'd0);
    check("mid rst tile_ready", 64'(tile_ready), 64'd1);
    tick();
    rst = 1'b0;
    row_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post rst valid%0d", i), 64'(row_valid),  64'd0);
      check($sformatf("post rst ready%0d", i), 64'(tile_ready), 64'd1);
    end
    send(mk_tile(9), 1'b0);
    check_row("post rst row0", 9, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
